// File: rtl/fifo_rd_stream_if.sv
// Read-side stream bundle: FIFO pop port, valid/ready output stream and status.
// master = the drain stage, slave = FIFO plus sink environment.
interface fifo_rd_stream_if #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 empty;
  logic [WORD_SIZE-1:0] r_word;
  logic                 ren;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out_data;
  logic [1:0]           occupancy;
  logic [CNT_WIDTH-1:0] word_cnt;

  modport master (
    input  empty, r_word, out_ready,
    output ren, out_valid, out_data, occupancy, word_cnt
  );

  modport slave (
    output empty, r_word, out_ready,
    input  ren, out_valid, out_data, occupancy, word_cnt
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read drain: turns the ren/empty/r_word pop port into a valid/ready stream
// through a 2-entry skid buffer, and counts delivered words (saturating).
module fifo_rd_stream #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  fifo_rd_stream_if.master bus
);

  logic                 inflight_q;
  logic [1:0]           occ_q, occ_d;
  logic [WORD_SIZE-1:0] mem_q [2];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 xfer;
  logic                 ren;
  logic [2:0]           used;

  assign xfer = (occ_q != 2'd0) & bus.out_ready;
  assign used = {1'b0, occ_q} + {2'b00, inflight_q};

  // Pop only when a slot is guaranteed free as the word lands next cycle.
  assign ren = ~bus.empty & rst & (used < (3'd2 + {2'b00, xfer}));

  always_comb begin
    occ_d = occ_q;
    unique case ({inflight_q, xfer})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      inflight_q <= ren;
      occ_q      <= occ_d;
      if (inflight_q) begin
        mem_q[wr_ptr_q] <= bus.r_word;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (xfer) begin
        rd_ptr_q <= ~rd_ptr_q;
        if (cnt_q != {CNT_WIDTH{1'b1}}) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.ren       = ren;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.occupancy = occ_q;
  assign bus.word_cnt  = cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural FIFO with 1-cycle read latency,
// output scoreboard, and a second 3-bit-counter instance for saturation.
module tb_fifo_rd_stream;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_stream_if #(.WORD_SIZE(8), .CNT_WIDTH(16)) b1 ();
  fifo_rd_stream_if #(.WORD_SIZE(8), .CNT_WIDTH(3))  b2 ();

  fifo_rd_stream #(.WORD_SIZE(8), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  fifo_rd_stream #(.WORD_SIZE(8), .CNT_WIDTH(3)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // FIFO model: wp advanced by the stimulus, rp by pops; data valid one clk after ren.
  logic [7:0] store [256];
  logic [7:0] wp = 8'd0;
  logic [7:0] rp = 8'd0;
  int         cyc = 0;

  assign b1.empty = (wp == rp);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (b1.ren && (wp != rp)) begin
      b1.r_word <= store[rp];
      rp        <= rp + 8'd1;
    end
  end

  task automatic push(input logic [7:0] w);
    store[wp] = w;
    wp        = wp + 8'd1;
  endtask

  logic e2 = 1'b1;
  assign b2.empty     = e2;
  assign b2.r_word    = 8'h5A;
  assign b2.out_ready = 1'b1;

  logic [7:0] got  [$];
  int         gcyc [$];
  int         n2 = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'd0;

  always @(negedge clk) begin
    check("occ_le2", 32'(b1.occupancy > 2'd2), 32'd0);
    check("ren_while_empty", 32'(b1.ren & b1.empty), 32'd0);
    if (rst && prev_hold) begin
      check("hold_valid", 32'(b1.out_valid), 32'd1);
      check("hold_data", 32'(b1.out_data), 32'(prev_data));
    end
    prev_hold = rst & b1.out_valid & ~b1.out_ready;
    prev_data = b1.out_data;
    if (rst && b1.out_valid && b1.out_ready) begin
      got.push_back(b1.out_data);
      gcyc.push_back(cyc);
    end
    if (rst && b2.out_valid) n2++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int  rel;
  logic seen;

  initial begin
    b1.out_ready = 1'b1;
    // 1. Reset with FIFO non-empty
    step(1);
    for (int i = 1; i <= 8; i++) push(8'(i));
    @(negedge clk);
    check("rst_ren", 32'(b1.ren), 32'd0);
    check("rst_valid", 32'(b1.out_valid), 32'd0);
    check("rst_cnt", 32'(b1.word_cnt), 32'd0);
    check("rst_occ", 32'(b1.occupancy), 32'd0);
    check("rst_data", 32'(b1.out_data), 32'd0);
    step(1);
    rst = 1'b1;
    rel = cyc;
    @(negedge clk);
    check("rel_ren", 32'(b1.ren), 32'd1);

    // 2. Full-rate stream, 2 clk latency
    step(14);
    check("stream_n", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("stream_data", (i < got.size()) ? 32'(got[i]) : 32'hFFFF, 32'(i + 1));
      check("stream_cyc", (i < gcyc.size()) ? 32'(gcyc[i]) : 32'hFFFF, 32'(rel + 2 + i));
    end
    check("stream_cnt", 32'(b1.word_cnt), 32'd8);

    // 3. Backpressure
    got.delete();
    b1.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h11 + i));
    step(6);
    check("bp_occ", 32'(b1.occupancy), 32'd2);
    check("bp_ren", 32'(b1.ren), 32'd0);
    check("bp_data", 32'(b1.out_data), 32'h11);
    check("bp_fifo_left", 32'(wp - rp), 32'd3);
    b1.out_ready = 1'b1;
    step(10);
    check("bp_n", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check("bp_order", (i < got.size()) ? 32'(got[i]) : 32'hFFFF, 32'(8'h11 + i));
    check("bp_cnt", 32'(b1.word_cnt), 32'd13);

    // 4. Alternating out_ready
    got.delete();
    for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
    for (int i = 0; i < 40; i++) begin
      b1.out_ready = (i % 2 == 0);
      step(1);
    end
    b1.out_ready = 1'b1;
    step(10);
    check("alt_n", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      check("alt_order", (i < got.size()) ? 32'(got[i]) : 32'hFFFF, 32'(8'h30 + i));
    check("alt_cnt", 32'(b1.word_cnt), 32'd29);

    // 5. Reset with a pop in flight
    for (int i = 0; i < 4; i++) push(8'(8'h50 + i));
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = b1.ren;
    end
    check("mid_ren_seen", 32'(seen), 32'd1);
    step(1);
    rst = 1'b0;
    wp  = rp;
    #1;
    check("mid_ren", 32'(b1.ren), 32'd0);
    check("mid_valid", 32'(b1.out_valid), 32'd0);
    check("mid_occ", 32'(b1.occupancy), 32'd0);
    check("mid_cnt", 32'(b1.word_cnt), 32'd0);
    check("mid_data", 32'(b1.out_data), 32'd0);
    step(2);
    rst = 1'b1;
    got.delete();
    step(3);
    check("mid_no_stale", 32'(got.size()), 32'd0);
    check("mid_valid_after", 32'(b1.out_valid), 32'd0);
    push(8'h77);
    step(6);
    check("mid_new_n", 32'(got.size()), 32'd1);
    check("mid_new_data", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF, 32'h77);
    check("mid_new_cnt", 32'(b1.word_cnt), 32'd1);

    // 6. Saturating 3-bit counter
    e2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step(1);
      seen = (n2 >= 5);
    end
    check("sat_reach5", 32'(seen), 32'd1);
    check("sat_mid", 32'(b2.word_cnt), 32'd5);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step(1);
      seen = (n2 >= 10);
    end
    check("sat_reach10", 32'(seen), 32'd1);
    e2 = 1'b0;
    e2 = 1'b1;
    step(6);
    check("sat_cnt", 32'(b2.word_cnt), 32'd7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
